uart_tx: RTL and testbench

- UART transmitter, 8N1 framing: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
- Counterpart to the team's UART receiver and shares its CLKS_PER_BIT convention, so a looped-back TX/RX pair interoperates directly.
- Accepts a byte on a one-cycle data-valid strobe and drives the serial line.
- Reports activity, plus a one-cycle done pulse at frame end.

---
 rtl/uart_tx.sv | 123 ++++++++++++
 tb/tb_uart_tx.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter (start 0, 8 data bits LSB first, stop 1).
// Ports: i_Clock, i_Reset (async, high), i_TX_DV/i_TX_Byte in; o_TX_Active/o_TX_Serial/o_TX_Done out.
module uart_tx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Active,
  output logic       o_TX_Serial,
  output logic       o_TX_Done
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    TX_START_BIT = 3'd1,
    TX_DATA_BITS = 3'd2,
    TX_STOP_BIT  = 3'd3,
    CLEANUP      = 3'd4
  } state_t;

  localparam logic [15:0] CNT_MAX = 16'(CLKS_PER_BIT - 1);

  state_t      state, state_n;
  logic [15:0] clk_cnt, clk_cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  tx_data, tx_data_n;
  logic        serial_n, active_n, done_n;
  logic        cnt_last;

  assign cnt_last = (clk_cnt == CNT_MAX);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      tx_data     <= '0;
      o_TX_Serial <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
    end else begin
      state       <= state_n;
      clk_cnt     <= clk_cnt_n;
      bit_idx     <= bit_idx_n;
      tx_data     <= tx_data_n;
      o_TX_Serial <= serial_n;
      o_TX_Active <= active_n;
      o_TX_Done   <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_idx_n = bit_idx;
    tx_data_n = tx_data;
    serial_n  = o_TX_Serial;
    active_n  = o_TX_Active;
    done_n    = 1'b0;
    unique case (state)
      // The cleanup cycle is also an accept slot, so a held strobe
      // re-frames every 10*CLKS_PER_BIT+1 clocks.
      IDLE, CLEANUP: begin
        state_n   = IDLE;
        clk_cnt_n = '0;
        bit_idx_n = '0;
        serial_n  = 1'b1;
        active_n  = 1'b0;
        if (i_TX_DV) begin
          tx_data_n = i_TX_Byte;
          state_n   = TX_START_BIT;
          serial_n  = 1'b0;
          active_n  = 1'b1;
        end
      end
      TX_START_BIT: begin
        if (!cnt_last) begin
          clk_cnt_n = clk_cnt + 16'd1;
        end else begin
          clk_cnt_n = '0;
          bit_idx_n = '0;
          state_n   = TX_DATA_BITS;
          serial_n  = tx_data[0];
        end
      end
      TX_DATA_BITS: begin
        if (!cnt_last) begin
          clk_cnt_n = clk_cnt + 16'd1;
        end else begin
          clk_cnt_n = '0;
          if (bit_idx != 3'd7) begin
            bit_idx_n = bit_idx + 3'd1;
            serial_n  = tx_data[bit_idx + 3'd1];
          end else begin
            bit_idx_n = '0;
            state_n   = TX_STOP_BIT;
            serial_n  = 1'b1;
          end
        end
      end
      TX_STOP_BIT: begin
        if (!cnt_last) begin
          clk_cnt_n = clk_cnt + 16'd1;
        end else begin
          clk_cnt_n = '0;
          state_n   = CLEANUP;
          done_n    = 1'b1;
          active_n  = 1'b0;
        end
      end
      default: begin
        state_n   = IDLE;
        clk_cnt_n = '0;
        bit_idx_n = '0;
        serial_n  = 1'b1;
        active_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench for uart_tx at CLKS_PER_BIT=4.
// Reference model tracks frame start time and derives the line from the 10-bit frame.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int FL  = 10 * CPB;

  logic       i_Clock = 1'b0;
  logic       clk_en  = 1'b0;
  logic       i_Reset = 1'b0;
  logic       i_TX_DV = 1'b0;
  logic [7:0] i_TX_Byte = 8'h00;
  logic       o_TX_Active, o_TX_Serial, o_TX_Done;

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock    (i_Clock),
    .i_Reset    (i_Reset),
    .i_TX_DV    (i_TX_DV),
    .i_TX_Byte  (i_TX_Byte),
    .o_TX_Active(o_TX_Active),
    .o_TX_Serial(o_TX_Serial),
    .o_TX_Done  (o_TX_Done)
  );

  always #5 if (clk_en) i_Clock = ~i_Clock;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic m_act = 1'b0;
  int m_t = 0;
  logic [7:0] m_byte = 8'h00;
  logic [2:0] e_out;
  logic line_q[$];
  int starts[$];

  // One clock: advance the model on the edge, then sample outputs.
  task automatic tick();
    logic [9:0] frame;
    @(posedge i_Clock);
    if (i_Reset) begin
      m_act = 1'b0;
    end else begin
      if (m_act) m_t++;
      if (i_TX_DV && (!m_act || m_t >= FL + 1)) begin
        m_act  = 1'b1;
        m_t    = 0;
        m_byte = i_TX_Byte;
        starts.push_back(cyc);
      end
    end
    cyc++;
    #1;
    line_q.push_back(o_TX_Serial);
    frame = {1'b1, m_byte, 1'b0};
    if (m_act && m_t < FL)       e_out = {frame[m_t / CPB], 2'b10};
    else if (m_act && m_t == FL) e_out = 3'b101;
    else                         e_out = 3'b100;
  endtask

  task automatic test_reset();
    i_Reset = 1'b1;
    #1;
    n_chk++;
    if ({o_TX_Serial, o_TX_Active, o_TX_Done} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_async: got %b want 100",
               {o_TX_Serial, o_TX_Active, o_TX_Done});
    end
    clk_en = 1'b1;
    repeat (3) tick();
    #2 i_Reset = 1'b0;
    repeat (5) begin
      tick();
      n_chk++;
      if ({o_TX_Serial, o_TX_Active, o_TX_Done} !== e_out) begin
        n_fail++;
        $display("FAIL reset_idle: got %b want %b",
                 {o_TX_Serial, o_TX_Active, o_TX_Done}, e_out);
      end
    end
  endtask

  task automatic test_single();
    int base, n_act, n_done;
    logic [9:0] want;
    want = 10'b1101001010;
    base = line_q.size();
    n_act = 0;
    n_done = 0;
    i_TX_DV = 1'b1;
    i_TX_Byte = 8'hA5;
    for (int i = 0; i < FL + 5; i++) begin
      tick();
      i_TX_DV = 1'b0;
      i_TX_Byte = 8'($urandom);
      if (o_TX_Active) n_act++;
      if (o_TX_Done) n_done++;
      n_chk++;
      if ({o_TX_Serial, o_TX_Active, o_TX_Done} !== e_out) begin
        n_fail++;
        $display("FAIL single_cyc%0d: got %b want %b", i,
                 {o_TX_Serial, o_TX_Active, o_TX_Done}, e_out);
      end
    end
    for (int k = 0; k < 10; k++) begin
      n_chk++;
      if (line_q[base + k * CPB + CPB / 2] !== want[k]) begin
        n_fail++;
        $display("FAIL single_bit%0d: got %b want %b", k,
                 line_q[base + k * CPB + CPB / 2], want[k]);
      end
    end
    n_chk++;
    if (n_act != FL) begin
      n_fail++;
      $display("FAIL single_active_len: got %0d want %0d", n_act, FL);
    end
    n_chk++;
    if (n_done != 1) begin
      n_fail++;
      $display("FAIL single_done_len: got %0d want 1", n_done);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      i_TX_DV = 1'b1;
      i_TX_Byte = 8'($urandom);
      for (int i = 0; i < FL + 1 + int'($urandom_range(0, 12)); i++) begin
        tick();
        i_TX_DV = 1'b0;
        i_TX_Byte = 8'($urandom);
        if (i < FL - 3 && $urandom_range(0, 5) == 0) i_TX_DV = 1'b1;
        n_chk++;
        if ({o_TX_Serial, o_TX_Active, o_TX_Done} !== e_out) begin
          n_fail++;
          $display("FAIL random_f%0d_c%0d: got %b want %b", f, i,
                   {o_TX_Serial, o_TX_Active, o_TX_Done}, e_out);
        end
      end
      i_TX_DV = 1'b0;
    end
  endtask

  task automatic test_loopback();
    logic [7:0] sent[$];
    logic [7:0] got[$];
    logic [7:0] b;
    int i;
    sent = '{8'h00, 8'hFF, 8'h3C, 8'($urandom), 8'($urandom)};
    line_q.delete();
    foreach (sent[s]) begin
      i_TX_DV = 1'b1;
      i_TX_Byte = sent[s];
      for (int c = 0; c < FL + 4; c++) begin
        tick();
        i_TX_DV = 1'b0;
        n_chk++;
        if ({o_TX_Serial, o_TX_Active, o_TX_Done} !== e_out) begin
          n_fail++;
          $display("FAIL loop_line_b%0d_c%0d: got %b want %b", s, c,
                   {o_TX_Serial, o_TX_Active, o_TX_Done}, e_out);
        end
      end
    end
    i = 0;
    while (i + FL <= line_q.size()) begin
      if (line_q[i] == 1'b0) begin
        for (int k = 0; k < 8; k++) b[k] = line_q[i + (k + 1) * CPB + CPB / 2];
        if (line_q[i + CPB / 2] == 1'b0 && line_q[i + 9 * CPB + CPB / 2] == 1'b1)
          got.push_back(b);
        i += FL;
      end else begin
        i++;
      end
    end
    n_chk++;
    if (got.size() != sent.size()) begin
      n_fail++;
      $display("FAIL loop_count: got %0d want %0d", got.size(), sent.size());
    end
    foreach (sent[s]) begin
      if (s < got.size()) begin
        n_chk++;
        if (got[s] !== sent[s]) begin
          n_fail++;
          $display("FAIL loop_byte%0d: got %h want %h", s, got[s], sent[s]);
        end
      end
    end
  endtask

  task automatic test_busy();
    int n0;
    n0 = starts.size();
    i_TX_DV = 1'b1;
    i_TX_Byte = 8'h55;
    for (int i = 0; i < FL + 8; i++) begin
      tick();
      i_TX_DV = (i == 9 || i == FL - 1);
      i_TX_Byte = i_TX_DV ? 8'hAA : 8'h55;
      n_chk++;
      if ({o_TX_Serial, o_TX_Active, o_TX_Done} !== e_out) begin
        n_fail++;
        $display("FAIL busy_c%0d: got %b want %b", i,
                 {o_TX_Serial, o_TX_Active, o_TX_Done}, e_out);
      end
    end
    n_chk++;
    if (starts.size() - n0 != 1) begin
      n_fail++;
      $display("FAIL busy_frames: got %0d want 1", starts.size() - n0);
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = starts.size();
    i_TX_DV = 1'b1;
    i_TX_Byte = 8'h81;
    for (int i = 0; i < 2 * FL + 10; i++) begin
      tick();
      n_chk++;
      if ({o_TX_Serial, o_TX_Active, o_TX_Done} !== e_out) begin
        n_fail++;
        $display("FAIL b2b_c%0d: got %b want %b", i,
                 {o_TX_Serial, o_TX_Active, o_TX_Done}, e_out);
      end
    end
    i_TX_DV = 1'b0;
    n_chk++;
    if (starts.size() - n0 < 2 || starts[n0 + 1] - starts[n0] != FL + 1) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d frames want spacing %0d",
               starts.size() - n0, FL + 1);
    end
    repeat (FL + 4) tick();
  endtask

  task automatic test_reset_mid();
    int n_done;
    n_done = 0;
    i_TX_DV = 1'b1;
    i_TX_Byte = 8'h00;
    repeat (4 * CPB + 2) begin
      tick();
      i_TX_DV = 1'b0;
    end
    #2 i_Reset = 1'b1;
    #1;
    n_chk++;
    if ({o_TX_Serial, o_TX_Active, o_TX_Done} !== 3'b100) begin
      n_fail++;
      $display("FAIL mid_reset_async: got %b want 100",
               {o_TX_Serial, o_TX_Active, o_TX_Done});
    end
    repeat (2) tick();
    #2 i_Reset = 1'b0;
    repeat (FL) begin
      tick();
      if (o_TX_Done) n_done++;
    end
    n_chk++;
    if (n_done != 0) begin
      n_fail++;
      $display("FAIL mid_no_done: got %0d want 0", n_done);
    end
    i_TX_DV = 1'b1;
    i_TX_Byte = 8'h12;
    for (int i = 0; i < FL + 4; i++) begin
      tick();
      i_TX_DV = 1'b0;
      n_chk++;
      if ({o_TX_Serial, o_TX_Active, o_TX_Done} !== e_out) begin
        n_fail++;
        $display("FAIL mid_resend_c%0d: got %b want %b", i,
                 {o_TX_Serial, o_TX_Active, o_TX_Done}, e_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_random();
    test_loopback();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
